// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter for one shared 4:1 mux.
// Issues a registered one-hot grant plus the matching 2-bit mux select and
// keeps ownership until the owner drops its request.
// Optional feature macro: ARB_HOLD_LIMIT_EN. When it is defined, an owner
// that has held the grant for MAX_HOLD cycles is pre-empted as soon as
// another requester is waiting.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic       HOLD_EN = 1'b1;
  localparam logic [7:0] CNT_SAT = 8'(MAX_HOLD - 1);
`else
  localparam logic       HOLD_EN = 1'b0;
  localparam logic [7:0] CNT_SAT = 8'hFF;
`endif
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  // 2-to-4 decode of a requester index into its one-hot grant.
  function automatic logic [3:0] dec2to4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Round-robin pick: returns {found, index}. Candidates are walked from
  // the farthest to the nearest so that the one closest to ptr wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      cand = p + 2'(i);
      if (r[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_e     state_q, state_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [1:0] sel_q,   sel_d;    // sel_q doubles as the current owner
  logic [3:0] gnt_q,   gnt_d;
  logic       busy_q,  busy_d;

  logic [3:0] others_s;
  logic [3:0] cand_s;
  logic [2:0] pick_s;
  logic [1:0] win_s;
  logic       hold_hit_s;
  logic       preempt_s;

  // Next-state logic: arbitration, handover, hold counting and release.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;

    // The owner's own bit is masked so it is never re-granted at its
    // release or pre-emption edge.
    others_s   = req & ~dec2to4(sel_q);
    cand_s     = (state_q == GRANT) ? others_s : req;
    pick_s     = rr_pick(cand_s, ptr_q);
    win_s      = pick_s[1:0];
    hold_hit_s = HOLD_EN & (cnt_q == HOLD_LAST);
    preempt_s  = hold_hit_s & (others_s != 4'b0000);

    case (state_q)
      IDLE: begin
        if (pick_s[2]) begin
          state_d = GRANT;
          sel_d   = win_s;
          gnt_d   = dec2to4(win_s);
          ptr_d   = win_s + 2'd1;
          cnt_d   = 8'd0;
          busy_d  = 1'b1;
        end else begin
          gnt_d  = 4'b0000;
          busy_d = 1'b0;
        end
      end
      GRANT: begin
        if (req[sel_q] && !preempt_s) begin
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end else if (pick_s[2]) begin
          // Handover at the same edge: no dead cycle between owners.
          sel_d  = win_s;
          gnt_d  = dec2to4(win_s);
          ptr_d  = win_s + 2'd1;
          cnt_d  = 8'd0;
          busy_d = 1'b1;
        end else begin
          // Release with nobody waiting; sel keeps the last owner.
          state_d = IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= 8'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_mux4_rr_arbiter;

  localparam int MAXH = 4;
`ifdef ARB_HOLD_LIMIT_EN
  localparam bit HOLD_TB = 1'b1;
  localparam int CAP     = MAXH - 1;
`else
  localparam bit HOLD_TB = 1'b0;
  localparam int CAP     = 255;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  mux4_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_owner = -1;   // -1 means nobody holds the mux
  int m_ptr   = 0;
  int m_cnt   = 0;
  int m_sel   = 0;
  bit m_ok    = 1'b0;

  function automatic int first_rr(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Model update at each rising edge from the sampled inputs.
  always @(posedge clk) begin
    int o, p, c, s, w;
    logic [3:0] oth;
    bit pre;
    o = m_owner; p = m_ptr; c = m_cnt; s = m_sel;
    if (rst_n === 1'b0) begin
      o = -1; p = 0; c = 0; s = 0;
      m_ok <= 1'b1;
    end else if (o < 0) begin
      w = first_rr(req, p);
      if (w >= 0) begin
        o = w; s = w; p = (w + 1) % 4; c = 0;
      end
    end else begin
      oth = req & ~(4'b0001 << o);
      pre = HOLD_TB && (c == MAXH - 1) && (oth != 4'b0000);
      if (req[o] && !pre) begin
        if (c < CAP) c = c + 1;
      end else begin
        w = first_rr(oth, p);
        if (w >= 0) begin
          o = w; s = w; p = (w + 1) % 4; c = 0;
        end else begin
          o = -1;
        end
      end
    end
    m_owner <= o; m_ptr <= p; m_cnt <= c; m_sel <= s;
  end

  // Compare DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    logic [3:0] eg;
    if (m_ok) begin
      eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      chk("model_gnt", gnt, eg);
      chk("model_sel", {2'b00, sel}, 4'(m_sel));
      chk("model_busy", {3'b000, busy}, {3'b000, m_owner >= 0});
    end
  end

  // Drive one cycle of inputs at the falling edge, then wait past the rise.
  task automatic cyc(input logic [3:0] r, input logic rn);
    @(negedge clk);
    req   = r;
    rst_n = rn;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_out(input string name, input logic [3:0] g, input logic [1:0] s, input logic b);
    chk({name, "_gnt"}, gnt, g);
    chk({name, "_sel"}, {2'b00, sel}, {2'b00, s});
    chk({name, "_busy"}, {3'b000, busy}, {3'b000, b});
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    logic [3:0] r;
    logic       rn;
    req   = 4'b0000;
    rst_n = 1'b0;

    // Reset then idle
    for (int i = 0; i < 2; i++) begin
      cyc(4'b0000, 1'b0);
      chk_out("reset", 4'b0000, 2'b00, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0000, 1'b1);
      chk_out("idle", 4'b0000, 2'b00, 1'b0);
    end

    // Single request
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0100, 1'b1);
      chk_out("single", 4'b0100, 2'b10, 1'b1);
    end
    cyc(4'b0000, 1'b1);
    chk_out("single_rel", 4'b0000, 2'b10, 1'b0);

    // Fairness rotation
    cyc(4'b0000, 1'b0);
    cyc(4'b1111, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk_out("fair", 4'b0001 << order[k], 2'(order[k]), 1'b1);
      cyc(4'b1111, 1'b1);
      cyc(4'b1111, 1'b1);
      if (k < 4) cyc(4'b1111 & ~(4'b0001 << order[k]), 1'b1);
    end

    // Wrap and skip
    cyc(4'b0000, 1'b1);
    cyc(4'b1000, 1'b1);
    chk_out("wrap_own3", 4'b1000, 2'b11, 1'b1);
    cyc(4'b0010, 1'b1);
    chk_out("wrap_skip", 4'b0010, 2'b01, 1'b1);
    cyc(4'b1101, 1'b1);
    chk_out("wrap_ptr2", 4'b0100, 2'b10, 1'b1);

    // Hold limit behaviour with req=0011 held
    cyc(4'b0000, 1'b0);
    for (int j = 0; j < 20; j++) begin
      cyc(4'b0011, 1'b1);
      chk("hold_gnt", gnt, (HOLD_TB && ((j / 4) % 2 == 1)) ? 4'b0010 : 4'b0001);
    end

    // Reset mid-grant
    cyc(4'b0000, 1'b1);
    cyc(4'b1000, 1'b1);
    chk_out("mid_pre", 4'b1000, 2'b11, 1'b1);
    cyc(4'b1000, 1'b0);
    chk_out("mid_rst", 4'b0000, 2'b00, 1'b0);
    cyc(4'b1001, 1'b1);
    chk_out("mid_after", 4'b0001, 2'b00, 1'b1);

    // Randomized traffic against the model
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      rn = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      cyc(r, rn);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
